// File: rtl/sram_bist_initiator.sv
// March-test initiator for the SRAM controller request port.
// Ports: clk, rst_n, start, seed, mem_* request/readback, busy, done, pass,
//        fail_addr (first miscompare), err_count (saturating).
module sram_bist_initiator #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam int L = RD_LATENCY;

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d, fail_d;
    logic [DATA_W-1:0] seed_q, seed_d, wdata_d, exp_now;
    logic [2:0]        dcnt, dcnt_d;
    logic              wr_d, rd_d, busy_d, done_d, pass_d;
    logic [7:0]        err_d;
    logic              accept, mis;

    // Read-compare delay line: expected data and address ride alongside
    // the outstanding read until its data returns.
    logic              dv   [L];
    logic [DATA_W-1:0] dexp [L];
    logic [ADDR_W-1:0] dadr [L];

    function automatic logic [DATA_W-1:0] pat(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] s
    );
        return DATA_W'(a) ^ s;
    endfunction

    // mem_addr and state are aligned, so the current state tells which
    // polarity the outstanding read expects.
    assign exp_now = (state == R1) ? ~pat(mem_addr, seed_q)
                                   :  pat(mem_addr, seed_q);
    assign mis = dv[L-1] && (mem_rdata != dexp[L-1]);

    always_comb begin
        state_d = state;
        addr_d  = mem_addr;
        dcnt_d  = '0;
        seed_d  = seed_q;
        accept  = start && (state == IDLE || state == DONE);
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W0;
                    addr_d  = '0;
                    seed_d  = seed;
                end
            end
            W0: begin
                if (mem_addr == LAST) begin
                    state_d = R0;
                    addr_d  = '0;
                end else begin
                    addr_d = mem_addr + 1'b1;
                end
            end
            R0: begin
                if (mem_addr == LAST) begin
                    state_d = W1;
                    addr_d  = LAST;
                end else begin
                    addr_d = mem_addr + 1'b1;
                end
            end
            W1: begin
                if (mem_addr == '0) begin
                    state_d = R1;
                    addr_d  = LAST;
                end else begin
                    addr_d = mem_addr - 1'b1;
                end
            end
            R1: begin
                if (mem_addr == '0) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = mem_addr - 1'b1;
                end
            end
            DRAIN: begin
                addr_d = '0;
                if (dcnt == 3'(L - 1)) state_d = DONE;
                else                   dcnt_d  = dcnt + 3'd1;
            end
            default: state_d = IDLE;
        endcase

        wr_d    = (state_d == W0) || (state_d == W1);
        rd_d    = (state_d == R0) || (state_d == R1);
        wdata_d = '0;
        if (state_d == W0) wdata_d =  pat(addr_d, seed_d);
        if (state_d == W1) wdata_d = ~pat(addr_d, seed_d);
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = (state_d == DONE);

        err_d  = err_count;
        fail_d = fail_addr;
        pass_d = pass;
        if (accept) begin
            err_d  = '0;
            fail_d = '0;
            pass_d = 1'b0;
        end else begin
            if (mis && err_count != 8'hFF) err_d = err_count + 8'd1;
            if (mis && err_count == 8'h00) fail_d = dadr[L-1];
            if (state == DRAIN && state_d == DONE) pass_d = (err_d == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seed_q    <= '0;
            dcnt      <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            seed_q    <= seed_d;
            dcnt      <= dcnt_d;
            mem_wr_en <= wr_d;
            mem_rd_en <= rd_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_addr <= fail_d;
            err_count <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                dv[i]   <= 1'b0;
                dexp[i] <= '0;
                dadr[i] <= '0;
            end
        end else begin
            dv[0]   <= mem_rd_en;
            dexp[0] <= exp_now;
            dadr[0] <= mem_addr;
            for (int i = 1; i < L; i++) begin
                dv[i]   <= dv[i-1];
                dexp[i] <= dexp[i-1];
                dadr[i] <= dadr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_initiator.sv
// Bench for sram_bist_initiator: latency-1 and latency-3 instances,
// behavioural SRAM models with fault injection, scoreboard of run results.
module tb_sram_bist_initiator;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start1 = 1'b0, start3 = 1'b0;
    logic [DW-1:0] seed1 = '0, seed3 = '0;
    logic          wr1, rd1, busy1, done1, pass1;
    logic          wr3, rd3, busy3, done3, pass3;
    logic [AW-1:0] addr1, fa1, addr3, fa3;
    logic [DW-1:0] wd1, wd3, rdat1, rdat3;
    logic [7:0]    ec1, ec3;

    sram_bist_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
        .mem_wr_en(wr1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_rdata(rdat1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_addr(fa1), .err_count(ec1)
    );

    sram_bist_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed3),
        .mem_wr_en(wr3), .mem_rd_en(rd3), .mem_addr(addr3),
        .mem_wdata(wd3), .mem_rdata(rdat3), .busy(busy3), .done(done3),
        .pass(pass3), .fail_addr(fa3), .err_count(ec3)
    );

    // Fault controls for the latency-1 memory
    logic          sa1_on = 1'b0;
    logic [AW-1:0] sa1_addr = '0;
    logic [DW-1:0] sa1_mask = '0;
    logic [DW-1:0] sa0_mask = '0;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v,
                                             input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = v;
        if (sa1_on && a == sa1_addr) r = r | sa1_mask;
        r = r & ~sa0_mask;
        return r;
    endfunction

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem3 [DEPTH];
    logic [DW-1:0] p3 [3];

    always @(posedge clk) begin
        if (wr1) mem1[addr1] <= wd1;
        if (rd1) rdat1 <= faulty(mem1[addr1], addr1);
    end

    always @(posedge clk) begin
        if (wr3) mem3[addr3] <= wd3;
        p3[0] <= mem3[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdat3 = p3[2];

    // Monitors
    int bc1 = 0, bc3 = 0, both1 = 0, both3 = 0;
    logic [DW-1:0] a5_q[$];
    always @(negedge clk) begin
        if (busy1) bc1++;
        if (busy3) bc3++;
        if (wr1 && rd1) both1++;
        if (wr3 && rd3) both3++;
        if (wr1 && addr1 == 10'd5) a5_q.push_back(wd1);
    end

    typedef struct {
        int which;
        int base;
        int bbase;
        int cycles;
        int pass;
        int err;
        int fa;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic do_start(input int which, input logic [DW-1:0] s,
                            input int cyc, input int ps, input int er,
                            input int fa);
        exp_t e;
        @(negedge clk);
        e.which  = which;
        e.base   = (which == 3) ? bc3 : bc1;
        e.bbase  = (which == 3) ? both3 : both1;
        e.cycles = cyc;
        e.pass   = ps;
        e.err    = er;
        e.fa     = fa;
        exp_q.push_back(e);
        if (which == 3) begin
            start3 = 1'b1;
            seed3  = s;
        end else begin
            start1 = 1'b1;
            seed1  = s;
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if ((which == 3) ? done3 : done1) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (e.which == 3) begin
            check("cycles3", bc3 - e.base, e.cycles);
            check("pass3", 32'(pass3), e.pass);
            check("err3", 32'(ec3), e.err);
            check("fa3", 32'(fa3), e.fa);
            check("busy3_lo", 32'(busy3), 32'd0);
            check("excl3", both3 - e.bbase, 32'd0);
        end else begin
            check("cycles", bc1 - e.base, e.cycles);
            check("pass", 32'(pass1), e.pass);
            check("err", 32'(ec1), e.err);
            check("fa", 32'(fa1), e.fa);
            check("busy_lo", 32'(busy1), 32'd0);
            check("excl", both1 - e.bbase, 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({wr1, rd1, busy1, done1, pass1}), 32'd0);
        check({tag, "_adr"}, 32'({addr1, fa1}), 32'd0);
        check({tag, "_dat"}, 32'({wd1, ec1}), 32'd0);
    endtask

    initial begin
        int a5_base;
        exp_t junk;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        check("rst3", 32'({busy3, done3, ec3}), 32'd0);
        rst_n = 1'b1;

        // Ideal memory, seed 0
        a5_base = a5_q.size();
        do_start(1, 8'h00, 4 * DEPTH + 1, 1, 0, 0);
        wait_done(1);
        check("a5_n", a5_q.size() - a5_base, 32'd2);
        if (a5_q.size() >= a5_base + 2) begin
            check("a5_w0", 32'(a5_q[a5_base]), 32'h05);
            check("a5_w1", 32'(a5_q[a5_base + 1]), 32'hFA);
        end

        // Bit 0 stuck-at-1 at 0x080; restart straight from DONE
        sa1_on   = 1'b1;
        sa1_addr = 10'h080;
        sa1_mask = 8'h01;
        do_start(1, 8'h00, 4 * DEPTH + 1, 0, 1, 10'h080);
        wait_done(1);
        sa1_on   = 1'b0;

        // Bit 3 stuck-at-0 everywhere: saturating count
        sa0_mask = 8'h08;
        do_start(1, 8'h00, 4 * DEPTH + 1, 0, 255, 10'h008);
        wait_done(1);
        sa0_mask = 8'h00;

        // Latency 3, seed A5
        do_start(3, 8'hA5, 4 * DEPTH + 3, 1, 0, 0);
        wait_done(3);

        // start mid-run is ignored
        do_start(1, 8'h3C, 4 * DEPTH + 1, 1, 0, 0);
        repeat (98) @(negedge clk);
        start1 = 1'b1;
        seed1  = 8'hC3;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1);

        // Async reset in the middle of R1
        do_start(1, 8'h11, 4 * DEPTH + 1, 1, 0, 0);
        repeat (3200) @(negedge clk);
        check("in_r1", 32'({busy1, rd1, wr1}), 32'b110);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        if (exp_q.size() > 0) junk = exp_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;

        // Clean run after abort
        do_start(1, 8'h5A, 4 * DEPTH + 1, 1, 0, 0);
        wait_done(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
